uart_rx_fifo: RTL and testbench

Parametrised UART receiver for the uart_alu family. It replaces the fixed-format receive path with configurable clock, baud, data width, parity and oversampling, and adds a buffered ready/valid output.
- An oversampling state machine deframes RX_i, checks parity and stop bit, and pushes good frames into a small show-ahead FIFO.
- Sits between the board-level RX pin and the ALU command parser.

---
 rtl/uart_rx_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a show-ahead ready/valid FIFO; define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 31500000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              RX_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);
    localparam int DIV   = (CLK_FREQ_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = DIV > 1 ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_W);
    localparam int AW    = $clog2(FIFO_DEPTH);
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_PH = OVERSAMPLE / 2;
`else
    localparam int SAMPLE_PH = OVERSAMPLE / 2 - 1;
`endif

    if (DIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_W < 5 || DATA_W > 9 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
        $error("uart_rx_fifo: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;

    state_e             state_q, state_d;
    logic [1:0]         sync_q;
    logic               rx_s, rx_prev_q;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]    os_cnt_q, os_cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic               par_err_q, par_err_d;
    logic               push_q, push_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               tick, start_det, sample_en, bit_val, par_calc;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q;
    logic               full, pop, do_push;

    // two-flop synchroniser on the line plus one flop of history for edge detect
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], RX_i};
            rx_prev_q <= rx_s;
        end
    end

    assign rx_s      = sync_q[1];
    assign tick      = div_cnt_q == DIV_W'(DIV - 1);
    assign start_det = (state_q == S_IDLE) && rx_prev_q && !rx_s;
    assign sample_en = tick && (os_cnt_q == OS_W'(SAMPLE_PH));
    assign par_calc  = (^shift_q) ^ bit_val;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;

    // capture the two early samples of the three-tick majority window
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            maj_q <= 2'b11;
        end else if (tick && os_cnt_q == OS_W'(SAMPLE_PH - 2)) begin
            maj_q[0] <= rx_s;
        end else if (tick && os_cnt_q == OS_W'(SAMPLE_PH - 1)) begin
            maj_q[1] <= rx_s;
        end
    end

    assign bit_val = (maj_q[0] & maj_q[1]) | (rx_s & (maj_q[0] | maj_q[1]));
`else
    assign bit_val = rx_s;
`endif

    // tick divider and in-bit phase counter, both restarted by a start edge
    always_comb begin
        div_cnt_d = (start_det || tick) ? '0 : div_cnt_q + 1'b1;
        os_cnt_d  = start_det ? '0 : !tick ? os_cnt_q :
                    (os_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // FSM next-state logic; stop returns to idle at mid-bit so back-to-back frames work
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = start_det ? S_START : S_IDLE;
            S_START:  state_d = !sample_en ? S_START : bit_val ? S_IDLE : S_DATA;
            S_DATA:   state_d = (sample_en && bit_cnt_q == BC_W'(DATA_W - 1)) ?
                                ((PARITY_MODE != 0) ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY: state_d = sample_en ? S_STOP : S_PARITY;
            S_STOP:   state_d = !sample_en ? S_STOP : bit_val ? S_IDLE : S_BREAK;
            S_BREAK:  state_d = rx_s ? S_IDLE : S_BREAK;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag, shift/parity datapath and the one-shot frame verdicts
    always_comb begin
        busy_o    = state_q != S_IDLE;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_err_d = par_err_q;
        push_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (sample_en) begin
            case (state_q)
                S_START: begin
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                end
                S_DATA: begin
                    shift_d   = {bit_val, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                S_PARITY: par_err_d = (PARITY_MODE == 1) ? !par_calc : par_calc;
                S_STOP: begin
                    ferr_d = !bit_val;
                    perr_d = bit_val && par_err_q;
                    push_d = bit_val && !par_err_q;
                end
                default: ;
            endcase
        end
    end

    // receive datapath registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_cnt_q <= '0;
            os_cnt_q  <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            push_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            os_cnt_q  <= os_cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_err_q <= par_err_d;
            push_q    <= push_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign full         = count_q == (AW + 1)'(FIFO_DEPTH);
    assign valid_o      = count_q != '0;
    assign pop          = valid_o && ready_i;
    assign do_push      = push_q && (!full || pop);
    assign overrun_o    = push_q && full && !pop;
    assign data_o       = valid_o ? mem_q[rd_ptr_q] : '0;

    // FIFO pointers and occupancy; a push into a full FIFO is accepted when a pop frees a slot
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_q + (AW + 1)'(do_push) - (AW + 1)'(pop);
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo, no-parity and even-parity instances
module tb_uart_rx_fifo;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx0, rx1, ready0, ready1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, perr_o0, perr_o1, ferr_o0, ferr_o1, ovr_o0, ovr_o1, busy0, busy1;
    int         checks = 0, errors = 0;
    int         vcnt0 = 0, vcnt1 = 0, perr0 = 0, perr1 = 0, ferr0 = 0, ferr1 = 0, ovr0 = 0, ovr1 = 0;
    logic [7:0] q0[$], q1[$];
    int         v, b;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_FREQ_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_W(8),
                   .PARITY_MODE(0), .FIFO_DEPTH(4)) dut0 (
        .clk_i(clk), .reset_ni(reset_n), .RX_i(rx0), .data_o(data0), .valid_o(valid0),
        .ready_i(ready0), .parity_err_o(perr_o0), .frame_err_o(ferr_o0), .overrun_o(ovr_o0),
        .busy_o(busy0));

    uart_rx_fifo #(.CLK_FREQ_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_W(8),
                   .PARITY_MODE(2), .FIFO_DEPTH(4)) dut1 (
        .clk_i(clk), .reset_ni(reset_n), .RX_i(rx1), .data_o(data1), .valid_o(valid1),
        .ready_i(ready1), .parity_err_o(perr_o1), .frame_err_o(ferr_o1), .overrun_o(ovr_o1),
        .busy_o(busy1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int d, input logic bv);
        if (d == 0) rx0 = bv;
        else        rx1 = bv;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int d, input logic [7:0] data, input bit has_par,
                              input logic par, input logic stop);
        drive_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d, data[i]);
        if (has_par) drive_bit(d, par);
        drive_bit(d, stop);
    endtask

    // scoreboard: pops on every handshake, counts valid cycles and flag pulses
    always @(negedge clk) begin
        if (valid0) vcnt0++;
        if (valid1) vcnt1++;
        if (perr_o0) perr0++;
        if (perr_o1) perr1++;
        if (ferr_o0) ferr0++;
        if (ferr_o1) ferr1++;
        if (ovr_o0) ovr0++;
        if (ovr_o1) ovr1++;
        if (valid0 && ready0) begin
            chk("dut0_word_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) chk("dut0_data", 32'(data0), 32'(q0.pop_front()));
        end
        if (valid1 && ready1) begin
            chk("dut1_word_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) chk("dut1_data", 32'(data1), 32'(q1.pop_front()));
        end
    end

    initial begin
        logic [7:0] pat;
        reset_n = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_valid0", 32'(valid0), 0);
        chk("rst_data0", 32'(data0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_flags0", 32'({perr_o0, ferr_o0, ovr_o0}), 0);
        chk("rst_valid1", 32'(valid1), 0);
        chk("rst_busy1", 32'(busy1), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 0xA5 without parity, busy falling at the stop mid-bit
        ready0 = 1'b1; v = vcnt0; q0.push_back(8'hA5); pat = 8'hA5;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(0, pat[i]);
        chk("a5_busy_in_frame", 32'(busy0), 1);
        rx0 = 1'b1;
        repeat (10 + LAT) @(posedge clk);
        @(negedge clk);
        chk("a5_busy_at_stop_sample", 32'(busy0), 1);
        @(negedge clk);
        chk("a5_busy_fall", 32'(busy0), 0);
        repeat (5 - LAT) @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;
        chk("a5_one_valid", 32'(vcnt0 - v), 1);
        chk("a5_drained", 32'(q0.size()), 0);
        chk("a5_no_flags", 32'(perr0 + ferr0 + ovr0), 0);

        // even parity: good and bad parity bit
        ready1 = 1'b1; v = vcnt1; q1.push_back(8'h07);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("par_ok_valid", 32'(vcnt1 - v), 1);
        chk("par_ok_drained", 32'(q1.size()), 0);
        chk("par_ok_no_err", 32'(perr1), 0);
        v = vcnt1;
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("par_bad_err", 32'(perr1), 1);
        chk("par_bad_no_valid", 32'(vcnt1 - v), 0);
        chk("par_bad_no_ferr", 32'(ferr1), 0);

        // bad stop bit followed by a long break, then a clean frame
        v = vcnt0; b = ferr0;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40 * 16) @(posedge clk);
        #1;
        chk("brk_one_ferr", 32'(ferr0 - b), 1);
        chk("brk_busy_held", 32'(busy0), 1);
        chk("brk_no_valid", 32'(vcnt0 - v), 0);
        chk("brk_no_perr", 32'(perr0), 0);
        rx0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("brk_busy_release", 32'(busy0), 0);
        q0.push_back(8'h55);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("brk_55_drained", 32'(q0.size()), 0);
        chk("brk_ferr_still_one", 32'(ferr0 - b), 1);

        // fill with ready low, fifth frame overruns, then drain in order
        ready0 = 1'b0; b = ovr0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) q0.push_back(8'(k));
            send_frame(0, 8'(k), 1'b0, 1'b0, 1'b1);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("full_one_overrun", 32'(ovr0 - b), 1);
        chk("full_valid", 32'(valid0), 1);
        chk("full_head", 32'(data0), 32'(q0[0]));
        ready0 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("full_drained", 32'(q0.size()), 0);
        chk("full_valid_fall", 32'(valid0), 0);

        // full FIFO with a pop in the push cycle of 0x06
        ready0 = 1'b0; b = ovr0;
        for (int k = 0; k < 4; k++) begin
            q0.push_back(8'h0A + 8'(k));
            send_frame(0, 8'h0A + 8'(k), 1'b0, 1'b0, 1'b1);
        end
        q0.push_back(8'h06); pat = 8'h06;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(0, pat[i]);
        rx0 = 1'b1;
        repeat (11 + LAT) @(posedge clk);
        #1 ready0 = 1'b1;
        @(negedge clk);
        chk("pp_push_cycle", 32'(busy0), 0);
        chk("pp_no_overrun", 32'(ovr_o0), 0);
        @(posedge clk);
        #1 ready0 = 1'b0;
        chk("pp_valid", 32'(valid0), 1);
        chk("pp_head", 32'(data0), 8'h0B);
        repeat (4 - LAT) @(posedge clk);
        #1;
        chk("pp_overrun_count", 32'(ovr0 - b), 0);
        ready0 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("pp_drained", 32'(q0.size()), 0);
        chk("pp_valid_fall", 32'(valid0), 0);

        // short low glitch on the idle line
        v = vcnt0; b = perr0 + ferr0 + ovr0;
        rx0 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx0 = 1'b1;
        @(negedge clk);
        chk("gl_busy_start", 32'(busy0), 1);
        repeat (20) @(posedge clk);
        #1;
        chk("gl_idle", 32'(busy0), 0);
        chk("gl_no_valid", 32'(vcnt0 - v), 0);
        chk("gl_no_flags", 32'(perr0 + ferr0 + ovr0 - b), 0);

`ifdef UART_RX_MAJORITY_EN
        // one-clock high glitch at the centre of data bit 3 of 0x00
        ready0 = 1'b1; v = vcnt0; q0.push_back(8'h00);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                rx0 = 1'b0;
                repeat (8) @(posedge clk);
                #1 rx0 = 1'b1;
                @(posedge clk);
                #1 rx0 = 1'b0;
                repeat (7) @(posedge clk);
                #1;
            end else begin
                drive_bit(0, 1'b0);
            end
        end
        drive_bit(0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("maj_one_valid", 32'(vcnt0 - v), 1);
        chk("maj_drained", 32'(q0.size()), 0);
`endif

        // reset in the middle of a frame with a word buffered
        ready0 = 1'b0; b = perr0 + ferr0 + ovr0;
        send_frame(0, 8'h99, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("mr_buffered", 32'(valid0), 1);
        rx0 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mr_busy", 32'(busy0), 1);
        reset_n = 1'b0;
        #1;
        chk("mr_busy_cleared", 32'(busy0), 0);
        chk("mr_valid_cleared", 32'(valid0), 0);
        chk("mr_data_cleared", 32'(data0), 0);
        rx0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("mr_idle", 32'(busy0), 0);
        chk("mr_empty", 32'(valid0), 0);
        chk("mr_no_flags", 32'(perr0 + ferr0 + ovr0 - b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
